// File: rtl/csa_mult_sequencer.sv
// Iterative unsigned multiplier: one 3:2 carry-save row per cycle, then one carry-propagate resolve.
// Optional macro CSA_MULT_EARLY_TERM_EN ends accumulation once the remaining multiplier bits are zero.
module csa_mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 abort,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           dbg_state
);
    // Handshakes: a transfer happens on the rising edge where valid && ready;
    // valid never depends on ready, and a raised res_valid holds until taken or aborted.

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t          state_q;
    logic [PW-1:0]   a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]   sum_q;
    logic [PW-1:0]   carry_q;  // holds carry already shifted left by one
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   result_q;
    logic            res_valid_q;

    logic [PW-1:0]   pp_d;
    logic [PW-1:0]   sum_d;
    logic [PW-1:0]   carry_d;
    logic [PW-2:0]   maj_lo;
    logic            accum_last;
    logic            accept;

    always_comb begin
        pp_d    = b_q[0] ? (a_q << count_q) : '0;
        sum_d   = sum_q ^ carry_q ^ pp_d;
        maj_lo  = (sum_q[PW-2:0] & carry_q[PW-2:0])
                | (sum_q[PW-2:0] & pp_d[PW-2:0])
                | (carry_q[PW-2:0] & pp_d[PW-2:0]);
        carry_d = {maj_lo, 1'b0};
`ifdef CSA_MULT_EARLY_TERM_EN
        accum_last = (count_q == CW'(WIDTH - 1)) || (b_q[WIDTH-1:1] == '0);
`else
        accum_last = (count_q == CW'(WIDTH - 1));
`endif
    end

    assign start_ready = (state_q == IDLE) && !abort;
    assign accept      = start_valid && start_ready;
    assign busy        = (state_q != IDLE);
    assign res_valid   = res_valid_q;
    assign result      = result_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            count_q     <= '0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= PW'(op_a);
                        b_q     <= op_b;
                        sum_q   <= '0;
                        carry_q <= '0;
                        count_q <= '0;
`ifdef CSA_MULT_EARLY_TERM_EN
                        state_q <= (op_b == '0) ? RESOLVE : ACCUM;
`else
                        state_q <= ACCUM;
`endif
                    end
                end
                ACCUM: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    b_q     <= b_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (accum_last) begin
                        state_q <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    result_q    <= sum_q + carry_q;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Bench for csa_mult_sequencer: WIDTH=8 and WIDTH=32 instances against an arithmetic reference.
// Honours CSA_MULT_EARLY_TERM_EN when computing expected latency.
module tb_csa_mult_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        sv8, sr8, ab8, busy8, rv8, rr8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic [1:0]  st8;

    logic        sv32, sr32, ab32, busy32, rv32, rr32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic [1:0]  st32;

    csa_mult_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .op_a(a8), .op_b(b8), .abort(ab8), .busy(busy8), .res_valid(rv8),
        .res_ready(rr8), .result(res8), .dbg_state(st8)
    );

    csa_mult_sequencer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv32), .start_ready(sr32),
        .op_a(a32), .op_b(b32), .abort(ab32), .busy(busy32), .res_valid(rv32),
        .res_ready(rr32), .result(res32), .dbg_state(st32)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [15:0] last8;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Edges from accept to res_valid, from the multiplier's highest set bit.
    function automatic int lat_model(input logic [31:0] b, input int w);
        int m;
        m = -1;
        for (int i = 0; i < w; i++) if (b[i]) m = i;
`ifdef CSA_MULT_EARLY_TERM_EN
        return (m < 0) ? 1 : m + 2;
`else
        return w + 1;
`endif
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!sr8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("start8_timeout", 64'(t), 64'(0));
        sv8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        sv8 = 1'b0;
    endtask

    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!rv8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string name);
        int lat;
        logic [63:0] exp;
        exp_q.push_back(64'({8'b0, a} * {8'b0, b}));
        start8(a, b);
        wait_valid8(lat);
        exp = exp_q.pop_front();
        check({name, "_lat"}, 64'(lat), 64'(lat_model(32'(b), 8)));
        check({name, "_res"}, 64'(res8), exp);
        last8 = exp[15:0];
        @(negedge clk);
        check({name, "_idle"}, {62'b0, busy8, sr8}, 64'b01);
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input string name);
        int lat;
        int t;
        exp_q.push_back(64'(a) * 64'(b));
        t = 0;
        @(negedge clk);
        while (!sr32 && t < 100) begin
            @(negedge clk);
            t++;
        end
        sv32 = 1'b1; a32 = a; b32 = b;
        @(negedge clk);
        sv32 = 1'b0;
        lat = 0;
        while (!rv32 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(lat_model(b, 32)));
        check({name, "_res"}, res32, exp_q.pop_front());
        @(negedge clk);
        check({name, "_idle"}, {62'b0, busy32, sr32}, 64'b01);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0;
        sv8 = 0; ab8 = 0; rr8 = 1; a8 = 0; b8 = 0;
        sv32 = 0; ab32 = 0; rr32 = 1; a32 = 0; b32 = 0;
        last8 = '0;
        #12;
        check("rst_busy", 64'(busy8), 64'(0));
        check("rst_valid", 64'(rv8), 64'(0));
        check("rst_result", 64'(res8), 64'(0));
        check("rst_result32", res32, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_start_ready", {62'b0, sr8, sr32}, 64'b11);

        vecs[0] = '{8'd3,   8'd5,    16'h000F};
        vecs[1] = '{8'hFF,  8'hFF,   16'hFE01};
        vecs[2] = '{8'hAB,  8'h01,   16'h00AB};
        vecs[3] = '{8'hAB,  8'h00,   16'h0000};
        vecs[4] = '{8'h01,  8'h80,   16'h0080};
        vecs[5] = '{8'h00,  8'h37,   16'h0000};
        vecs[6] = '{8'h80,  8'h81,   16'h4080};
        for (int i = 0; i < 7; i++) begin
            start8(vecs[i].a, vecs[i].b);
            wait_valid8(lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(lat_model(32'(vecs[i].b), 8)));
            check($sformatf("vec%0d_res", i), 64'(res8), 64'(vecs[i].exp));
            @(negedge clk);
            check($sformatf("vec%0d_idle", i), {62'b0, busy8, sr8}, 64'b01);
        end

        // Backpressure: DONE holds its product until the consumer takes it.
        rr8 = 1'b0;
        start8(8'd3, 8'd5);
        wait_valid8(lat);
        check("bp_lat", 64'(lat), 64'(lat_model(32'd5, 8)));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {44'b0, res8, rv8, sr8, busy8, 1'b0}, {44'b0, 16'h000F, 4'b1010});
        end
        rr8 = 1'b1;
        @(negedge clk);
        check("bp_release", {62'b0, busy8, sr8}, 64'b01);
        last8 = 16'h000F;

        // Abort mid-accumulation: no product, result keeps its previous value.
        start8(8'hAB, 8'hCD);
        repeat (4) @(negedge clk);
        ab8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0;
        check("abort_idle", {62'b0, busy8, rv8}, 64'b00);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rv8) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'(0));
        check("abort_result_kept", 64'(res8), 64'(last8));
        run8(8'd7, 8'd9, "post_abort");

        // Abort and start together in IDLE: the start is refused.
        @(negedge clk);
        sv8 = 1'b1; ab8 = 1'b1; a8 = 8'd2; b8 = 8'd3;
        #1;
        check("abort_start_ready", 64'(sr8), 64'(0));
        @(negedge clk);
        sv8 = 1'b0; ab8 = 1'b0;
        check("abort_start_busy", 64'(busy8), 64'(0));

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
            run8(ra, rb, $sformatf("rnd%0d", i));
        end

        run32(32'hFFFFFFFF, 32'hFFFFFFFF, "w32_max");
        for (int i = 0; i < 4; i++) begin
            run32($urandom, $urandom >> $urandom_range(0, 31), $sformatf("w32_rnd%0d", i));
        end

        // Asynchronous reset between edges while accumulating.
        start8(8'h12, 8'h34);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {45'b0, busy8, rv8, res8}, 64'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("async_rst_ready", {62'b0, sr8, busy8}, 64'b10);
        run8(8'd6, 8'd7, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
